// File: rtl/rr_fifo_drain_arbiter.sv
// ---------------------------------------------------------------------------
// rr_fifo_drain_arbiter
//   Output-side stage of a router port. Drains NUM_IN input FIFOs (registered
//   read data, valid one cycle after the read enable) into a single
//   valid/ready output link through a 2-entry output buffer.
//
//   Arbitration is round-robin starting after the last released input.
//   With RR_PACKET_LOCK_EN defined the grant is held (wormhole lock) until a
//   flit with its tail bit (DATA_WIDTH-1) set has been captured. Without it
//   the tail bit is plain data and the grant is released after every
//   captured flit, giving flit-level interleaving.
//
//   Optional feature macro: RR_PACKET_LOCK_EN
//
// Ports
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset
//   empty_i  per-FIFO empty flag
//   data_i   per-FIFO read data, FIFO k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rd_en_o  per-FIFO read enable, at most one bit high
//   data_o   output flit (buffer head)
//   valid_o  output flit valid
//   ready_i  downstream accepts the flit
//   grant_o  one-hot locked input, 0 while idle
// ---------------------------------------------------------------------------

// Per-input slice: gates the read enable and steers that FIFO's read data
// onto the shared capture bus when this input holds the grant.
module rr_fifo_drain_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  empty,
  input  logic                  sel,
  input  logic                  issue_ok,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_sel
);
  assign rd_en    = sel & ~empty & issue_ok;
  assign data_sel = sel ? data : '0;
endmodule

module rr_fifo_drain_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_IN-1:0]            empty_i,
  input  logic [NUM_IN*DATA_WIDTH-1:0] data_i,
  output logic [NUM_IN-1:0]            rd_en_o,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [NUM_IN-1:0]            grant_o
);
  localparam int IDX_WIDTH = $clog2(NUM_IN);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                               state_q;
  logic [IDX_WIDTH-1:0]                 rr_ptr_q;
  logic [IDX_WIDTH-1:0]                 gidx_q;
  logic [NUM_IN-1:0]                    grant_q;
  logic                                 pend_q;   // read issued last cycle, data_i valid now
  logic [1:0]                           count_q;
  logic [1:0][DATA_WIDTH-1:0]           buf_q;    // entry 0 is the head

  logic                                 issue_ok;
  logic [NUM_IN-1:0][DATA_WIDTH-1:0]    lane_data;
  logic [DATA_WIDTH-1:0]                cap_data;
  logic                                 cap_tail;
  logic                                 rel;
  logic                                 push;
  logic                                 pop;

  logic                                 arb_found;
  logic [IDX_WIDTH-1:0]                 arb_idx;
  logic [IDX_WIDTH-1:0]                 cand;
  logic [NUM_IN-1:0]                    arb_oh;

  // Issue depends only on registers and empty_i; ready_i stays out of this
  // path. !pend_q limits us to one outstanding read, and count_q < 2 plus
  // that single outstanding read guarantees the buffer never overflows.
  assign issue_ok = (state_q == LOCK) && !pend_q && (count_q < 2'd2);

  for (genvar k = 0; k < NUM_IN; k++) begin : g_lane
    rr_fifo_drain_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .empty    (empty_i[k]),
      .sel      (grant_q[k]),
      .issue_ok (issue_ok),
      .data     (data_i[k*DATA_WIDTH +: DATA_WIDTH]),
      .rd_en    (rd_en_o[k]),
      .data_sel (lane_data[k])
    );
  end

  // Grant is one-hot (or 0), so OR-ing the steered lanes is the data mux.
  always_comb begin
    cap_data = '0;
    for (int k = 0; k < NUM_IN; k++) cap_data |= lane_data[k];
  end

`ifdef RR_PACKET_LOCK_EN
  assign cap_tail = cap_data[DATA_WIDTH-1];
`else
  assign cap_tail = 1'b1;
`endif

  // The grant is still held while its last read is being captured, so the
  // release happens at the capture edge.
  assign rel  = (state_q == LOCK) && pend_q && cap_tail;
  assign push = pend_q;
  assign pop  = valid_o && ready_i;

  // Round-robin search: rr_ptr+1, rr_ptr+2, ... modulo NUM_IN.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    arb_oh    = '0;
    for (int i = 1; i <= NUM_IN; i++) begin
      cand = IDX_WIDTH'((int'(rr_ptr_q) + i) % NUM_IN);
      if (!arb_found && !empty_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
    arb_oh[arb_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= IDX_WIDTH'(NUM_IN - 1);
      gidx_q   <= '0;
      grant_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_found) begin
            grant_q <= arb_oh;
            gidx_q  <= arb_idx;
            state_q <= LOCK;
          end
        end
        LOCK: begin
          // An emptied locked FIFO simply stalls here; no other input is
          // considered until release.
          if (rel) begin
            rr_ptr_q <= gidx_q;
            grant_q  <= '0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output buffer: 2 entries, shift-on-pop so the head is always entry 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q  <= 1'b0;
      count_q <= '0;
      buf_q   <= '0;
    end else begin
      pend_q <= |rd_en_o;
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) buf_q[0] <= cap_data;
          else                 buf_q[1] <= cap_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          buf_q[0] <= buf_q[1];
          count_q  <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            buf_q[0] <= cap_data;
          end else begin
            buf_q[0] <= buf_q[1];
            buf_q[1] <= cap_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = buf_q[0];
  assign grant_o = grant_q;

endmodule

// File: tb/tb_rr_fifo_drain_arbiter.sv
module tb_rr_fifo_drain_arbiter;
  localparam int NUM_IN = 4;
  localparam int DW     = 8;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic [NUM_IN-1:0]       empty_i;
  logic [NUM_IN*DW-1:0]    data_i;
  logic [NUM_IN-1:0]       rd_en_o;
  logic [DW-1:0]           data_o;
  logic                    valid_o;
  logic                    ready_i;
  logic [NUM_IN-1:0]       grant_o;

  rr_fifo_drain_arbiter #(.NUM_IN(NUM_IN), .DATA_WIDTH(DW)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .empty_i (empty_i),
    .data_i  (data_i),
    .rd_en_o (rd_en_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .grant_o (grant_o)
  );

  always #5 clk_i = ~clk_i;

  // FIFO model: registered read data, cleared by the same reset.
  logic [DW-1:0]               mem [NUM_IN][16];
  int                          wp [NUM_IN];
  int                          rp [NUM_IN];
  logic [NUM_IN-1:0][DW-1:0]   rdata;
  int                          uflow = 0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_IN; k++) rp[k] <= 0;
      rdata <= '0;
    end else begin
      for (int k = 0; k < NUM_IN; k++)
        if (rd_en_o[k] && rp[k] != wp[k]) begin
          rdata[k] <= mem[k][rp[k] % 16];
          rp[k]    <= rp[k] + 1;
        end
    end
  end

  always_comb begin
    empty_i = '1;
    for (int k = 0; k < NUM_IN; k++) empty_i[k] = (rp[k] == wp[k]);
  end
  assign data_i = rdata;

  // Underflow / one-hot monitor.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      for (int k = 0; k < NUM_IN; k++) if (rd_en_o[k] && empty_i[k]) uflow <= uflow + 1;
      if ($countones(rd_en_o) > 1) uflow <= uflow + 1;
    end
  end

  int total = 0;
  int bad   = 0;
  logic [DW-1:0]     got [$];
  logic [NUM_IN-1:0] gtrace [$];
  logic [NUM_IN-1:0] last_g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fpush(input int f, input logic [DW-1:0] d);
    mem[f][wp[f] % 16] = d;
    wp[f] = wp[f] + 1;
  endtask

  task automatic step(input logic rdy);
    @(negedge clk_i);
    ready_i = rdy;
    #1;
    if (valid_o && ready_i) got.push_back(data_o);
    if (grant_o != last_g) begin
      gtrace.push_back(grant_o);
      last_g = grant_o;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    for (int k = 0; k < NUM_IN; k++) wp[k] = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic collect(input int n, input int bound);
    for (int c = 0; c < bound && got.size() < n; c++) step(1'b1);
  endtask

  task automatic chk_seq(input string name, input logic [DW-1:0] exp [6], input int n);
    chk({name, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_%0d", name, i), (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF, {24'h0, exp[i]});
  endtask

  typedef struct {
    int                push_f;
    logic [DW-1:0]     push_d;
    logic              rdy;
    logic [NUM_IN-1:0] rd;
    logic [NUM_IN-1:0] gnt;
    logic              vld;
    logic [DW-1:0]     dat;
  } vec_t;

  vec_t          tbl [6];
  logic [DW-1:0] exp [6];
  int            pulses;

  initial begin
    // single-flit packet on FIFO0, cycle by cycle
    tbl[0] = '{0,  8'h85, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00};
    tbl[1] = '{-1, 8'h00, 1'b1, 4'b0001, 4'b0001, 1'b0, 8'h00};
    tbl[2] = '{-1, 8'h00, 1'b1, 4'b0000, 4'b0001, 1'b0, 8'h00};
    tbl[3] = '{-1, 8'h00, 1'b1, 4'b0000, 4'b0000, 1'b1, 8'h85};
    tbl[4] = '{-1, 8'h00, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00};
    tbl[5] = '{-1, 8'h00, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00};

    rst_ni  = 1'b0;
    ready_i = 1'b0;
    last_g  = '0;
    for (int k = 0; k < NUM_IN; k++) wp[k] = 0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_rd_en", rd_en_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_data",  data_o,  0);
    chk("rst_grant", grant_o, 0);
    rst_ni = 1'b1;

    // --- table: latency of a single-flit packet
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      ready_i = tbl[i].rdy;
      if (tbl[i].push_f >= 0) fpush(tbl[i].push_f, tbl[i].push_d);
      #1;
      chk($sformatf("t%0d_rd_en", i), rd_en_o, tbl[i].rd);
      chk($sformatf("t%0d_grant", i), grant_o, tbl[i].gnt);
      chk($sformatf("t%0d_valid", i), valid_o, tbl[i].vld);
      if (tbl[i].vld) chk($sformatf("t%0d_data", i), data_o, tbl[i].dat);
    end

    // --- two 3-flit packets on FIFO1 / FIFO2 (rr_ptr now 0)
    got.delete(); gtrace.delete(); last_g = grant_o;
    step(1'b1);
    fpush(1, 8'h01); fpush(1, 8'h02); fpush(1, 8'h83);
    fpush(2, 8'h11); fpush(2, 8'h12); fpush(2, 8'h84);
    collect(6, 80);
`ifdef RR_PACKET_LOCK_EN
    exp = '{8'h01, 8'h02, 8'h83, 8'h11, 8'h12, 8'h84};
`else
    exp = '{8'h01, 8'h11, 8'h02, 8'h12, 8'h83, 8'h84};
`endif
    chk_seq("pkt_order", exp, 6);
    chk("gtrace_len_ok", gtrace.size() >= 3, 1);
    if (gtrace.size() >= 3) begin
      chk("gtrace0", gtrace[0], 4'b0010);
      chk("gtrace1", gtrace[1], 4'b0000);
      chk("gtrace2", gtrace[2], 4'b0100);
    end

    // --- backpressure: 4 flits on FIFO0, ready low for 10 cycles
    got.delete();
    step(1'b0);
    fpush(0, 8'h21); fpush(0, 8'h22); fpush(0, 8'h23); fpush(0, 8'hA4);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b0);
      if (rd_en_o[0]) pulses++;
      if (valid_o) chk($sformatf("bp_hold_%0d", c), data_o, 8'h21);
    end
    chk("bp_pulses", pulses, 2);
    chk("bp_valid", valid_o, 1);
    collect(4, 40);
    exp = '{8'h21, 8'h22, 8'h23, 8'hA4, 8'h00, 8'h00};
    chk_seq("bp_order", exp, 4);

    // --- locked FIFO3 runs dry mid-packet while FIFO0 waits
    do_reset();
    got.delete();
    step(1'b1);
    fpush(3, 8'h33);
    step(1'b1);
    fpush(0, 8'h81);
    for (int c = 0; c < 8; c++) begin
      step(1'b1);
`ifdef RR_PACKET_LOCK_EN
      chk($sformatf("stall_grant_%0d", c), grant_o, 4'b1000);
      chk($sformatf("stall_rd0_%0d", c), rd_en_o[0], 0);
`endif
    end
    fpush(3, 8'h80);
    collect(3, 40);
`ifdef RR_PACKET_LOCK_EN
    exp = '{8'h33, 8'h80, 8'h81, 8'h00, 8'h00, 8'h00};
`else
    exp = '{8'h33, 8'h81, 8'h80, 8'h00, 8'h00, 8'h00};
`endif
    chk_seq("stall_order", exp, 3);

    // --- asynchronous reset with a full buffer
    do_reset();
    step(1'b0);
    fpush(1, 8'h41); fpush(1, 8'h42); fpush(1, 8'hC3);
    repeat (8) step(1'b0);
    chk("pre_rst_valid", valid_o, 1);
    chk("pre_rst_grant_nz", grant_o != 0, 1);
    #2;
    rst_ni = 1'b0;
    for (int k = 0; k < NUM_IN; k++) wp[k] = 0;
    #1;
    chk("arst_valid", valid_o, 0);
    chk("arst_rd_en", rd_en_o, 0);
    chk("arst_grant", grant_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    last_g = '0;
    step(1'b1);
    fpush(2, 8'h91); fpush(0, 8'h92);
    step(1'b1);
    chk("post_rst_grant", grant_o, 4'b0001);

    repeat (5) step(1'b1);
    chk("no_underflow_onehot", uflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
